simt_reg_file: RTL and testbench
================================

# simt_reg_file

Parametrised per-thread register file for the SIMT core; successor to the fixed 16×8 file. Adds asynchronous reset, registered reads with write-first bypass, a second write port for load writeback, multiple predicates per thread, a per-thread clear, and a pending-load scoreboard. It sits between the issue stage, the ALU writeback and the memory-load writeback.

## Interface
- NUM_THREADS, 16, threads per core.
- NUM_GPR, 8, general registers per thread, r4..r(3+NUM_GPR); must be ≤12.
- DATA_W, 18, register width.
- NUM_PRED, 2, predicate bits per thread.
- BLOCK_DIM, 1, value of r2.
- THREAD_IDX, 0, value of r3.
- TID_W = $clog2(NUM_THREADS), PIDX_W = max(1,$clog2(NUM_PRED)) (derived).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous and active-high.
- block_idx  in  DATA_W  value of r1.
- rd_en, rd_thread  in  1, TID_W  read request.
- rs1, rs2, rd_chk  in  4 each  source and destination registers. rd_chk is used only for the hazard check.
- reg1_out, reg2_out  out  DATA_W  registered read data.
- pred_out  out  NUM_PRED  registered predicates of the thread that was read.
- rd_valid  out  1  read data valid.
- hazard  out  1  combinational; rs1, rs2 or rd_chk has a load pending.
- wr0_en, wr0_thread, wr0_rd, wr0_data  in  1, TID_W, 4, DATA_W  ALU writeback.
- wr1_en, wr1_thread, wr1_rd, wr1_data  in  1, TID_W, 4, DATA_W  load writeback.
- pred_wr_en, pred_wr_thread, pred_wr_idx, pred_wr_data  in  1, TID_W, PIDX_W, 1.
- pend_set_en, pend_thread, pend_rd  in  1, TID_W, 4  load issued; marks rd pending.
- clr_en, clr_thread  in  1, TID_W  zero one thread's state.

## Operation
- Register map:
  - r0 reads 0.
  - r1 reads block_idx.
  - r2 reads BLOCK_DIM.
  - r3 reads THREAD_IDX.
  - r4..r(3+NUM_GPR) are per-thread GPRs.
  - Addresses above the GPR range read 0; writes and pending-sets to them are ignored.
- Writes to r0..r3 are ignored.
- Write priority for the same thread and register: clr_en first, then wr1, then wr0. Different targets write in parallel.
- clr_en in one cycle zeroes all GPRs, predicates and pending bits of clr_thread.
- Scoreboard: one pending bit per thread per GPR.
  - pend_set_en sets the bit for pend_thread, pend_rd.
  - wr1_en clears the bit for wr1_thread, wr1_rd.
  - Set and clear on the same entry in the same cycle: set wins.
- hazard is the OR of the pending bits for rd_thread at rs1, rs2 and rd_chk, gated by rd_en.
  - A clear arriving in the same cycle masks its bit, because the bypass delivers the data.
  - A set arriving in the same cycle is not visible until the next cycle.
  - hazard does not block the read; the issue stage decides what to do with it.
- Bypass is write-first. If a read and a write (or clear) hit the same thread and register in the same cycle, the outputs present the post-write value. This uses the same priority as the array write.
- pred_out likewise reflects a same-cycle pred_wr or clr.
- block_idx is sampled in the read-request cycle.

## Timing
- Read latency: 1 cycle.
  - A request in cycle N produces reg1_out, reg2_out, pred_out and rd_valid=1 after the edge ending cycle N.
  - rd_valid=0 when rd_en=0; data outputs hold their last value.
- Writes, predicate writes, clears and scoreboard updates take effect at the edge.
- Reset values, taken asynchronously on rst:
  - All GPRs, predicates and pending bits are 0.
  - reg1_out, reg2_out and pred_out are 0; rd_valid is 0.
  - hazard is 0.
- Reset in the middle of a read: rd_valid drops immediately, and no data from that read appears after reset deasserts.
- First read after rst deasserts is accepted in the same cycle.

## Structure
- simt_pkg holds:
  - DATA_W and REG_ADDR_W=4.
  - Shared-register constants REG_ZERO=0, REG_BIDX=1, REG_BDIM=2, REG_TIDX=3, GPR_BASE=4.
  - The typedef reg_addr_t.
- Sub-module simt_scoreboard: pending-bit array, set/clear priority, and the combinational hazard lookup. Parameters NUM_THREADS and NUM_GPR.
- GPR storage, write muxing, bypass and output registers stay in simt_reg_file.

## Test plan
- Reset, then read thread 3 with rs1=r0, rs2=r3 and THREAD_IDX=5 → next cycle reg1_out=0, reg2_out=5, rd_valid=1.
- Both write ports target thread 2 r6: wr0_data=0x111, wr1_data=0x222, with a same-cycle read of r6 → next cycle reg1_out=0x222; a later read returns 0x222.
- pend_set thread 1 r5, then read rs1=r5 → hazard=1. wr1 to thread 1 r5 with data 0x3FFFF while reading r5 in the same cycle → hazard=0, reg1_out=0x3FFFF next cycle.
- pend_set and wr1 on thread 0 r7 in the same cycle → the bit stays set; a read of r7 next cycle gives hazard=1.
- Write thread 4 r4=0x55 and predicate 1=1; then clr_en thread 4 in the same cycle as a read of r4 → reg1_out=0, pred_out=0; other threads keep their values.
- Assert rst while rd_en=1 and thread 0 r4=0x10 → rd_valid=0 and outputs 0 immediately; a read of r4 after reset returns 0.

Source files
------------

// File: rtl/simt_pkg.sv
// Shared constants and types for the SIMT per-thread register file.
// r0..r3 are read-only shared registers; GPRs start at r4.
package simt_pkg;

    localparam int DATA_W     = 18;
    localparam int REG_ADDR_W = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 4'd0;
    localparam reg_addr_t REG_BIDX = 4'd1;
    localparam reg_addr_t REG_BDIM = 4'd2;
    localparam reg_addr_t REG_TIDX = 4'd3;
    localparam reg_addr_t GPR_BASE = 4'd4;

    // True when the address falls inside r4..r(3+num_gpr).
    function automatic logic is_gpr(input reg_addr_t addr, input int num_gpr);
        return (int'(addr) >= int'(GPR_BASE)) && (int'(addr) < (int'(GPR_BASE) + num_gpr));
    endfunction

endpackage

// File: rtl/simt_reg_file_if.sv
// Issue / writeback bus of the SIMT register file: read request and response,
// two write ports, predicate write, load-pending set and per-thread clear.
interface simt_reg_file_if #(
    parameter int NUM_THREADS = 16,
    parameter int DATA_W      = simt_pkg::DATA_W,
    parameter int NUM_PRED    = 2
);
    import simt_pkg::*;

    localparam int TID_W  = $clog2(NUM_THREADS);
    localparam int PIDX_W = (NUM_PRED > 1) ? $clog2(NUM_PRED) : 1;

    logic [DATA_W-1:0]   block_idx;
    logic                rd_en;
    logic [TID_W-1:0]    rd_thread;
    reg_addr_t           rs1;
    reg_addr_t           rs2;
    reg_addr_t           rd_chk;
    logic [DATA_W-1:0]   reg1_out;
    logic [DATA_W-1:0]   reg2_out;
    logic [NUM_PRED-1:0] pred_out;
    logic                rd_valid;
    logic                hazard;
    logic                wr0_en;
    logic [TID_W-1:0]    wr0_thread;
    reg_addr_t           wr0_rd;
    logic [DATA_W-1:0]   wr0_data;
    logic                wr1_en;
    logic [TID_W-1:0]    wr1_thread;
    reg_addr_t           wr1_rd;
    logic [DATA_W-1:0]   wr1_data;
    logic                pred_wr_en;
    logic [TID_W-1:0]    pred_wr_thread;
    logic [PIDX_W-1:0]   pred_wr_idx;
    logic                pred_wr_data;
    logic                pend_set_en;
    logic [TID_W-1:0]    pend_thread;
    reg_addr_t           pend_rd;
    logic                clr_en;
    logic [TID_W-1:0]    clr_thread;

    modport master (
        output block_idx, rd_en, rd_thread, rs1, rs2, rd_chk,
        output wr0_en, wr0_thread, wr0_rd, wr0_data,
        output wr1_en, wr1_thread, wr1_rd, wr1_data,
        output pred_wr_en, pred_wr_thread, pred_wr_idx, pred_wr_data,
        output pend_set_en, pend_thread, pend_rd, clr_en, clr_thread,
        input  reg1_out, reg2_out, pred_out, rd_valid, hazard
    );

    modport slave (
        input  block_idx, rd_en, rd_thread, rs1, rs2, rd_chk,
        input  wr0_en, wr0_thread, wr0_rd, wr0_data,
        input  wr1_en, wr1_thread, wr1_rd, wr1_data,
        input  pred_wr_en, pred_wr_thread, pred_wr_idx, pred_wr_data,
        input  pend_set_en, pend_thread, pend_rd, clr_en, clr_thread,
        output reg1_out, reg2_out, pred_out, rd_valid, hazard
    );

endinterface

// File: rtl/simt_scoreboard.sv
// Pending-load scoreboard: one bit per thread per GPR. A load issue sets the
// bit, load writeback clears it, a thread clear wipes the whole row. The hazard
// lookup is combinational and hides bits being cleared this cycle, since the
// read bypass already delivers the incoming value.
module simt_scoreboard
    import simt_pkg::*;
#(
    parameter int NUM_THREADS = 16,
    parameter int NUM_GPR     = 8,
    localparam int TID_W      = $clog2(NUM_THREADS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en_i,
    input  logic [TID_W-1:0] set_thread_i,
    input  reg_addr_t        set_rd_i,
    input  logic             clr_en_i,
    input  logic [TID_W-1:0] clr_thread_i,
    input  reg_addr_t        clr_rd_i,
    input  logic             flush_en_i,
    input  logic [TID_W-1:0] flush_thread_i,
    input  logic             rd_en_i,
    input  logic [TID_W-1:0] rd_thread_i,
    input  reg_addr_t        rs1_i,
    input  reg_addr_t        rs2_i,
    input  reg_addr_t        rd_chk_i,
    output logic             hazard_o
);

    localparam int GIDX_W = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

    logic [NUM_GPR-1:0] pend_q [NUM_THREADS];
    logic [NUM_GPR-1:0] row_s;
    logic               set_ok_s;
    logic               clr_ok_s;
    logic [GIDX_W-1:0]  set_idx_s;
    logic [GIDX_W-1:0]  clr_idx_s;

    function automatic logic [GIDX_W-1:0] gidx(input reg_addr_t a);
        return GIDX_W'(a - GPR_BASE);
    endfunction

    function automatic logic row_hit(input reg_addr_t a, input logic [NUM_GPR-1:0] row);
        logic hit;
        if (is_gpr(a, NUM_GPR)) begin
            hit = row[gidx(a)];
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Decode set/clear targets; writes outside the GPR range are dropped
    always_comb begin
        set_ok_s  = set_en_i && is_gpr(set_rd_i, NUM_GPR);
        clr_ok_s  = clr_en_i && is_gpr(clr_rd_i, NUM_GPR);
        set_idx_s = gidx(set_rd_i);
        clr_idx_s = gidx(clr_rd_i);
    end

    // Pending bits: thread clear beats set, set beats writeback clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pend_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int g = 0; g < NUM_GPR; g++) begin
                    if (flush_en_i && (flush_thread_i == TID_W'(t))) begin
                        pend_q[t][g] <= 1'b0;
                    end else if (set_ok_s && (set_thread_i == TID_W'(t)) && (set_idx_s == GIDX_W'(g))) begin
                        pend_q[t][g] <= 1'b1;
                    end else if (clr_ok_s && (clr_thread_i == TID_W'(t)) && (clr_idx_s == GIDX_W'(g))) begin
                        pend_q[t][g] <= 1'b0;
                    end else begin
                        pend_q[t][g] <= pend_q[t][g];
                    end
                end
            end
        end
    end

    // Pending row of the reading thread with same-cycle clears masked out
    always_comb begin
        row_s = pend_q[rd_thread_i];
        if (flush_en_i && (flush_thread_i == rd_thread_i)) begin
            row_s = '0;
        end else if (clr_ok_s && (clr_thread_i == rd_thread_i)) begin
            row_s[clr_idx_s] = 1'b0;
        end else begin
            row_s = pend_q[rd_thread_i];
        end
    end

    // Hazard if any source or the destination check has a load outstanding
    always_comb begin
        hazard_o = rd_en_i && (row_hit(rs1_i, row_s) || row_hit(rs2_i, row_s) || row_hit(rd_chk_i, row_s));
    end

endmodule

// File: rtl/simt_reg_file.sv
// Per-thread register file for the SIMT core. Registered two-operand read with
// write-first bypass, ALU (wr0) and load (wr1) write ports, per-thread
// predicates, a one-cycle per-thread clear, and the pending-load scoreboard.
// NUM_GPR must not exceed 12 so the GPRs fit in the 4-bit register space.
module simt_reg_file #(
    parameter int NUM_THREADS = 16,
    parameter int NUM_GPR     = 8,
    parameter int DATA_W      = simt_pkg::DATA_W,
    parameter int NUM_PRED    = 2,
    parameter int BLOCK_DIM   = 1,
    parameter int THREAD_IDX  = 0
) (
    input  logic            clk,
    input  logic            rst,
    simt_reg_file_if.slave  bus
);
    import simt_pkg::*;

    localparam int TID_W  = $clog2(NUM_THREADS);
    localparam int PIDX_W = (NUM_PRED > 1) ? $clog2(NUM_PRED) : 1;
    localparam int GIDX_W = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

    logic [DATA_W-1:0]   gpr_q [NUM_THREADS][NUM_GPR];
    logic [NUM_PRED-1:0] pred_q [NUM_THREADS];
    logic [DATA_W-1:0]   reg1_q, reg1_d;
    logic [DATA_W-1:0]   reg2_q, reg2_d;
    logic [NUM_PRED-1:0] pred_out_q, pred_out_d;
    logic                rd_valid_q;
    logic                wr0_ok_s, wr1_ok_s;
    logic [GIDX_W-1:0]   wr0_idx_s, wr1_idx_s;
    logic [GIDX_W-1:0]   rs1_idx_s, rs2_idx_s;
    logic                rd_clr_s;

    function automatic logic [GIDX_W-1:0] gidx(input reg_addr_t a);
        return GIDX_W'(a - GPR_BASE);
    endfunction

    // Post-write GPR value; shared by the array update and the read bypass
    function automatic logic [DATA_W-1:0] gpr_next(
        input logic [DATA_W-1:0] cur,
        input logic              clr_hit,
        input logic              wr1_hit,
        input logic              wr0_hit,
        input logic [DATA_W-1:0] d1,
        input logic [DATA_W-1:0] d0
    );
        logic [DATA_W-1:0] v;
        if (clr_hit) begin
            v = '0;
        end else if (wr1_hit) begin
            v = d1;
        end else if (wr0_hit) begin
            v = d0;
        end else begin
            v = cur;
        end
        return v;
    endfunction

    // Post-write predicate vector; shared by the array update and the read bypass
    function automatic logic [NUM_PRED-1:0] pred_next(
        input logic [NUM_PRED-1:0] cur,
        input logic                clr_hit,
        input logic                wr_hit,
        input logic [PIDX_W-1:0]   idx,
        input logic                bit_val
    );
        logic [NUM_PRED-1:0] v;
        v = cur;
        if (clr_hit) begin
            v = '0;
        end else if (wr_hit && (int'(idx) < NUM_PRED)) begin
            v[idx] = bit_val;
        end else begin
            v = cur;
        end
        return v;
    endfunction

    // Register map: shared registers, GPRs, zero above the GPR range
    function automatic logic [DATA_W-1:0] operand(
        input reg_addr_t         a,
        input logic [DATA_W-1:0] bidx,
        input logic [DATA_W-1:0] gpr_val
    );
        logic [DATA_W-1:0] v;
        case (a)
            REG_ZERO: v = '0;
            REG_BIDX: v = bidx;
            REG_BDIM: v = DATA_W'(BLOCK_DIM);
            REG_TIDX: v = DATA_W'(THREAD_IDX);
            default: begin
                if (is_gpr(a, NUM_GPR)) begin
                    v = gpr_val;
                end else begin
                    v = '0;
                end
            end
        endcase
        return v;
    endfunction

    // Write port decode; writes to r0..r3 or above the GPR range are dropped
    always_comb begin
        wr0_ok_s  = bus.wr0_en && is_gpr(bus.wr0_rd, NUM_GPR);
        wr1_ok_s  = bus.wr1_en && is_gpr(bus.wr1_rd, NUM_GPR);
        wr0_idx_s = gidx(bus.wr0_rd);
        wr1_idx_s = gidx(bus.wr1_rd);
    end

    // GPR array: clear, then load writeback, then ALU writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int g = 0; g < NUM_GPR; g++) begin
                    gpr_q[t][g] <= '0;
                end
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int g = 0; g < NUM_GPR; g++) begin
                    gpr_q[t][g] <= gpr_next(gpr_q[t][g],
                        bus.clr_en && (bus.clr_thread == TID_W'(t)),
                        wr1_ok_s && (bus.wr1_thread == TID_W'(t)) && (wr1_idx_s == GIDX_W'(g)),
                        wr0_ok_s && (bus.wr0_thread == TID_W'(t)) && (wr0_idx_s == GIDX_W'(g)),
                        bus.wr1_data, bus.wr0_data);
                end
            end
        end
    end

    // Predicate array: clear beats predicate write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pred_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pred_q[t] <= pred_next(pred_q[t],
                    bus.clr_en && (bus.clr_thread == TID_W'(t)),
                    bus.pred_wr_en && (bus.pred_wr_thread == TID_W'(t)),
                    bus.pred_wr_idx, bus.pred_wr_data);
            end
        end
    end

    // Read operands with write-first bypass of same-cycle writes and clears
    always_comb begin
        rd_clr_s  = bus.clr_en && (bus.clr_thread == bus.rd_thread);
        rs1_idx_s = gidx(bus.rs1);
        rs2_idx_s = gidx(bus.rs2);
        reg1_d = operand(bus.rs1, bus.block_idx,
            gpr_next(gpr_q[bus.rd_thread][rs1_idx_s], rd_clr_s,
                wr1_ok_s && (bus.wr1_thread == bus.rd_thread) && (wr1_idx_s == rs1_idx_s),
                wr0_ok_s && (bus.wr0_thread == bus.rd_thread) && (wr0_idx_s == rs1_idx_s),
                bus.wr1_data, bus.wr0_data));
        reg2_d = operand(bus.rs2, bus.block_idx,
            gpr_next(gpr_q[bus.rd_thread][rs2_idx_s], rd_clr_s,
                wr1_ok_s && (bus.wr1_thread == bus.rd_thread) && (wr1_idx_s == rs2_idx_s),
                wr0_ok_s && (bus.wr0_thread == bus.rd_thread) && (wr0_idx_s == rs2_idx_s),
                bus.wr1_data, bus.wr0_data));
        pred_out_d = pred_next(pred_q[bus.rd_thread], rd_clr_s,
            bus.pred_wr_en && (bus.pred_wr_thread == bus.rd_thread),
            bus.pred_wr_idx, bus.pred_wr_data);
    end

    // Output registers: capture on a read, hold otherwise; valid follows rd_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg1_q     <= '0;
            reg2_q     <= '0;
            pred_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                reg1_q     <= reg1_d;
                reg2_q     <= reg2_d;
                pred_out_q <= pred_out_d;
            end else begin
                reg1_q     <= reg1_q;
                reg2_q     <= reg2_q;
                pred_out_q <= pred_out_q;
            end
        end
    end

    assign bus.reg1_out = reg1_q;
    assign bus.reg2_out = reg2_q;
    assign bus.pred_out = pred_out_q;
    assign bus.rd_valid = rd_valid_q;

    simt_scoreboard #(
        .NUM_THREADS (NUM_THREADS),
        .NUM_GPR     (NUM_GPR)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .set_en_i       (bus.pend_set_en),
        .set_thread_i   (bus.pend_thread),
        .set_rd_i       (bus.pend_rd),
        .clr_en_i       (bus.wr1_en),
        .clr_thread_i   (bus.wr1_thread),
        .clr_rd_i       (bus.wr1_rd),
        .flush_en_i     (bus.clr_en),
        .flush_thread_i (bus.clr_thread),
        .rd_en_i        (bus.rd_en),
        .rd_thread_i    (bus.rd_thread),
        .rs1_i          (bus.rs1),
        .rs2_i          (bus.rs2),
        .rd_chk_i       (bus.rd_chk),
        .hazard_o       (bus.hazard)
    );

endmodule

// File: tb/tb_simt_reg_file.sv
// Bench for simt_reg_file: expected read results are queued when a read is
// issued and popped when the registered outputs appear one cycle later.
module tb_simt_reg_file;

    localparam int NT = 16;
    localparam int NG = 8;
    localparam int DW = 18;
    localparam int NP = 2;

    typedef struct {
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic [NP-1:0] pr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    simt_reg_file_if #(.NUM_THREADS(NT), .DATA_W(DW), .NUM_PRED(NP)) bus ();

    simt_reg_file #(
        .NUM_THREADS(NT), .NUM_GPR(NG), .DATA_W(DW), .NUM_PRED(NP),
        .BLOCK_DIM(1), .THREAD_IDX(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle();
        bus.rd_en = 1'b0; bus.rd_thread = 4'd0; bus.rs1 = 4'd0; bus.rs2 = 4'd0; bus.rd_chk = 4'd0;
        bus.wr0_en = 1'b0; bus.wr0_thread = 4'd0; bus.wr0_rd = 4'd0; bus.wr0_data = 18'd0;
        bus.wr1_en = 1'b0; bus.wr1_thread = 4'd0; bus.wr1_rd = 4'd0; bus.wr1_data = 18'd0;
        bus.pred_wr_en = 1'b0; bus.pred_wr_thread = 4'd0; bus.pred_wr_idx = 1'b0; bus.pred_wr_data = 1'b0;
        bus.pend_set_en = 1'b0; bus.pend_thread = 4'd0; bus.pend_rd = 4'd0;
        bus.clr_en = 1'b0; bus.clr_thread = 4'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] th, input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] chk);
        bus.rd_en = 1'b1; bus.rd_thread = th; bus.rs1 = a1; bus.rs2 = a2; bus.rd_chk = chk;
    endtask

    task automatic expect_rd(input logic [DW-1:0] r1, input logic [DW-1:0] r2, input logic [NP-1:0] pr);
        exp_t x;
        x.r1 = r1; x.r2 = r2; x.pr = pr;
        exp_q.push_back(x);
    endtask

    task automatic wr0(input logic [3:0] th, input logic [3:0] a, input logic [DW-1:0] d);
        bus.wr0_en = 1'b1; bus.wr0_thread = th; bus.wr0_rd = a; bus.wr0_data = d;
    endtask

    task automatic wr1(input logic [3:0] th, input logic [3:0] a, input logic [DW-1:0] d);
        bus.wr1_en = 1'b1; bus.wr1_thread = th; bus.wr1_rd = a; bus.wr1_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.block_idx = 18'd0;
        #2;
        total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b0, 18'd0, 18'd0, 2'd0}) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out});
        end
        total++;
        if (bus.hazard !== 1'b0) begin
            bad++; $display("FAIL reset_hazard: got %b want 0", bus.hazard);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_shared_regs();
        rd(4'd3, 4'd0, 4'd3, 4'd0); expect_rd(18'd0, 18'd5, 2'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL shared_r0_r3: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        rd(4'd3, 4'd12, 4'd15, 4'd0); expect_rd(18'd0, 18'd0, 2'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL above_gpr_range: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        bus.block_idx = 18'h01234;
        rd(4'd3, 4'd1, 4'd2, 4'd0); expect_rd(18'h01234, 18'd1, 2'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL shared_r1_r2: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle();
        bus.block_idx = 18'h02222;
        tick();
        total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out} !== {1'b0, 18'h01234, 18'd1}) begin
            bad++; $display("FAIL idle_hold: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out}, {1'b0, 18'h01234, 18'd1});
        end
    endtask

    task automatic test_write_priority();
        idle(); wr0(4'd2, 4'd6, 18'h00111); wr1(4'd2, 4'd6, 18'h00222);
        rd(4'd2, 4'd6, 4'd6, 4'd0); expect_rd(18'h00222, 18'h00222, 2'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL wr_prio_bypass: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); rd(4'd2, 4'd6, 4'd4, 4'd0); expect_rd(18'h00222, 18'd0, 2'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL wr_prio_stored: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); wr0(4'd2, 4'd12, 18'h3AAAA); wr1(4'd2, 4'd1, 18'h1BBBB); bus.block_idx = 18'h00777;
        rd(4'd2, 4'd1, 4'd12, 4'd0); expect_rd(18'h00777, 18'd0, 2'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL wr_ignored: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); wr1(4'd15, 4'd11, 18'h2BBBB); wr0(4'd15, 4'd4, 18'h00ABC);
        tick();
        idle(); rd(4'd15, 4'd11, 4'd4, 4'd0); expect_rd(18'h2BBBB, 18'h00ABC, 2'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL wr_parallel: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
    endtask

    task automatic test_hazard();
        idle(); bus.pend_set_en = 1'b1; bus.pend_thread = 4'd1; bus.pend_rd = 4'd5;
        rd(4'd1, 4'd5, 4'd0, 4'd0); expect_rd(18'd0, 18'd0, 2'd0);
        #1; total++;
        if (bus.hazard !== 1'b0) begin
            bad++; $display("FAIL hz_set_same_cycle: got %b want 0", bus.hazard);
        end
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL hz_set_read: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); rd(4'd1, 4'd5, 4'd0, 4'd0);
        #1; total++;
        if (bus.hazard !== 1'b1) begin
            bad++; $display("FAIL hz_rs1: got %b want 1", bus.hazard);
        end
        bus.rd_en = 1'b0;
        #1; total++;
        if (bus.hazard !== 1'b0) begin
            bad++; $display("FAIL hz_gated: got %b want 0", bus.hazard);
        end
        tick();
        idle(); rd(4'd1, 4'd0, 4'd0, 4'd5); expect_rd(18'd0, 18'd0, 2'd0);
        #1; total++;
        if (bus.hazard !== 1'b1) begin
            bad++; $display("FAIL hz_rd_chk: got %b want 1", bus.hazard);
        end
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL hz_rd_chk_data: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); wr1(4'd1, 4'd5, 18'h3FFFF); rd(4'd1, 4'd5, 4'd0, 4'd0); expect_rd(18'h3FFFF, 18'd0, 2'd0);
        #1; total++;
        if (bus.hazard !== 1'b0) begin
            bad++; $display("FAIL hz_clear_mask: got %b want 0", bus.hazard);
        end
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL hz_clear_bypass: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); rd(4'd1, 4'd0, 4'd5, 4'd0); expect_rd(18'd0, 18'h3FFFF, 2'd0);
        #1; total++;
        if (bus.hazard !== 1'b0) begin
            bad++; $display("FAIL hz_cleared: got %b want 0", bus.hazard);
        end
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL hz_cleared_data: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
    endtask

    task automatic test_set_wins();
        idle(); bus.pend_set_en = 1'b1; bus.pend_thread = 4'd0; bus.pend_rd = 4'd7; wr1(4'd0, 4'd7, 18'h000C3);
        tick();
        idle(); rd(4'd0, 4'd7, 4'd0, 4'd0); expect_rd(18'h000C3, 18'd0, 2'd0);
        #1; total++;
        if (bus.hazard !== 1'b1) begin
            bad++; $display("FAIL set_wins: got %b want 1", bus.hazard);
        end
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL set_wins_data: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); wr1(4'd0, 4'd7, 18'h000C3);
        tick();
    endtask

    task automatic test_clear();
        idle(); wr0(4'd4, 4'd4, 18'h00055); wr1(4'd5, 4'd4, 18'h00066);
        bus.pred_wr_en = 1'b1; bus.pred_wr_thread = 4'd4; bus.pred_wr_idx = 1'b1; bus.pred_wr_data = 1'b1;
        tick();
        idle(); bus.pred_wr_en = 1'b1; bus.pred_wr_thread = 4'd5; bus.pred_wr_idx = 1'b0; bus.pred_wr_data = 1'b1;
        bus.pend_set_en = 1'b1; bus.pend_thread = 4'd4; bus.pend_rd = 4'd8;
        rd(4'd4, 4'd4, 4'd0, 4'd0); expect_rd(18'h00055, 18'd0, 2'b10);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL clr_before: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); bus.clr_en = 1'b1; bus.clr_thread = 4'd4; rd(4'd4, 4'd4, 4'd0, 4'd0); expect_rd(18'd0, 18'd0, 2'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL clr_bypass: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); rd(4'd4, 4'd4, 4'd8, 4'd8); expect_rd(18'd0, 18'd0, 2'd0);
        #1; total++;
        if (bus.hazard !== 1'b0) begin
            bad++; $display("FAIL clr_pending: got %b want 0", bus.hazard);
        end
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL clr_stored: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); rd(4'd5, 4'd4, 4'd0, 4'd0); expect_rd(18'h00066, 18'd0, 2'b01);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL clr_other_thread: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle(); bus.pred_wr_en = 1'b1; bus.pred_wr_thread = 4'd6; bus.pred_wr_idx = 1'b1; bus.pred_wr_data = 1'b1;
        rd(4'd6, 4'd0, 4'd0, 4'd0); expect_rd(18'd0, 18'd0, 2'b10);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL pred_bypass: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
    endtask

    task automatic test_reset_mid_read();
        idle(); wr0(4'd0, 4'd4, 18'h00010);
        tick();
        idle(); rd(4'd0, 4'd4, 4'd0, 4'd0); expect_rd(18'h00010, 18'd0, 2'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL pre_reset_read: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        #2;
        rst = 1'b1;
        #1; total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out, bus.hazard} !== {1'b0, 18'd0, 18'd0, 2'd0, 1'b0}) begin
            bad++; $display("FAIL rst_mid_read: got %h want 0", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out, bus.hazard});
        end
        tick();
        total++;
        if ({bus.rd_valid, bus.reg1_out} !== {1'b0, 18'd0}) begin
            bad++; $display("FAIL rst_held: got %h want 0", {bus.rd_valid, bus.reg1_out});
        end
        rst = 1'b0;
        rd(4'd0, 4'd4, 4'd0, 4'd0); expect_rd(18'd0, 18'd0, 2'd0);
        tick();
        e = exp_q.pop_front(); total++;
        if ({bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out} !== {1'b1, e.r1, e.r2, e.pr}) begin
            bad++; $display("FAIL post_reset_read: got %h want %h", {bus.rd_valid, bus.reg1_out, bus.reg2_out, bus.pred_out}, {1'b1, e.r1, e.r2, e.pr});
        end
        idle();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_shared_regs();
        test_write_priority();
        test_hazard();
        test_set_wins();
        test_clear();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
